// File: rtl/sad_search_ctrl.sv
// Motion-search controller: streams candidate blocks into the 8x8 SAD engine,
// retires the returning results and tracks the minimum SAD with its motion vector.
module sad_search_ctrl #(
  parameter int unsigned SAD_LATENCY = 5,
  parameter int unsigned MV_W        = 12
) (
  input  logic            clk,
  input  logic            aclr,
  input  logic            start,
  input  logic [511:0]    cur_block,
  input  logic            thresh_en,
  input  logic [13:0]     thresh,
  input  logic            cand_valid,
  output logic            cand_ready,
  input  logic [511:0]    cand_pixels,
  input  logic [MV_W-1:0] cand_mv,
  input  logic            cand_last,
  output logic [511:0]    xpixels,
  output logic [511:0]    ypixels,
  input  logic [13:0]     sad,
  output logic            busy,
  output logic            done,
  output logic [13:0]     best_sad,
  output logic [MV_W-1:0] best_mv,
  output logic [15:0]     cand_count,
  output logic            early_exit
);

  localparam int unsigned DEPTH = SAD_LATENCY + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] tv_q, tv_d;
  logic [MV_W-1:0]  tmv_q [DEPTH];
  logic [511:0]     xpix_q, ypix_q;
  logic             thr_en_q;
  logic [13:0]      thr_q;
  logic [13:0]      best_sad_q;
  logic [MV_W-1:0]  best_mv_q;
  logic [15:0]      cnt_q;
  logic             ee_q;
  logic             accept, retire, hit, start_ok;

  assign accept   = cand_valid && cand_ready;
  assign retire   = tv_q[DEPTH-1];
  assign hit      = retire && thr_en_q && (sad <= thr_q);
  assign start_ok = (state_q == IDLE) && start;

  // One tag per cycle: an idle slot shifts in as an invalid tag.
  assign tv_d = {tv_q[DEPTH-2:0], accept};

  always_comb begin
    state_d    = state_q;
    cand_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        cand_ready = 1'b1;
        busy       = 1'b1;
        if ((accept && cand_last) || hit) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Tags left after this edge's shift are the lower stages.
        if (tv_q[DEPTH-2:0] == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q    <= IDLE;
      tv_q       <= '0;
      xpix_q     <= '0;
      ypix_q     <= '0;
      thr_en_q   <= 1'b0;
      thr_q      <= '0;
      best_sad_q <= '1;
      best_mv_q  <= '0;
      cnt_q      <= '0;
      ee_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      tv_q    <= tv_d;
      if (start_ok) begin
        ypix_q     <= cur_block;
        thr_en_q   <= thresh_en;
        thr_q      <= thresh;
        best_sad_q <= '1;
        best_mv_q  <= '0;
        cnt_q      <= '0;
        ee_q       <= 1'b0;
      end
      if (accept) xpix_q <= cand_pixels;
      if (retire) begin
        if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
        if (sad < best_sad_q) begin
          best_sad_q <= sad;
          best_mv_q  <= tmv_q[DEPTH-1];
        end
        if (hit) ee_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    tmv_q[0] <= cand_mv;
    for (int unsigned i = 1; i < DEPTH; i++) tmv_q[i] <= tmv_q[i-1];
  end

  assign xpixels    = xpix_q;
  assign ypixels    = ypix_q;
  assign best_sad   = best_sad_q;
  assign best_mv    = best_mv_q;
  assign cand_count = cnt_q;
  assign early_exit = ee_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: behavioural SAD engine plus a per-candidate
// scoreboard folded into a min-SAD model at each expected retire edge.
module tb_sad_search_ctrl;

  localparam int LAT = 5;
  localparam int MVW = 12;

  typedef struct {
    logic [13:0]    s;
    logic [MVW-1:0] mv;
    int             rc;
  } sb_t;

  typedef enum {M_RUN, M_DRAIN, M_DONE} mst_e;

  logic           clk = 1'b0;
  logic           aclr, start, thresh_en, cand_valid, cand_last;
  logic [511:0]   cur_block, cand_pixels, xpixels, ypixels;
  logic [13:0]    thresh, sad, best_sad;
  logic [MVW-1:0] cand_mv, best_mv;
  logic           cand_ready, busy, done, early_exit;
  logic [15:0]    cand_count;

  logic [13:0]    eng [LAT] = '{default: '0};
  sb_t            sb [$];
  logic [511:0]   c_pix [64];
  logic [MVW-1:0] c_mv [64];
  bit             vpat [$];
  int             checks = 0, errors = 0;
  int             last_acc, done_at;
  logic [13:0]    m_best;
  logic [MVW-1:0] m_mv;
  int             m_cnt;
  bit             m_ee;

  sad_search_ctrl #(.SAD_LATENCY(LAT), .MV_W(MVW)) dut (
    .clk(clk), .aclr(aclr), .start(start), .cur_block(cur_block),
    .thresh_en(thresh_en), .thresh(thresh), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .cand_pixels(cand_pixels), .cand_mv(cand_mv),
    .cand_last(cand_last), .xpixels(xpixels), .ypixels(ypixels), .sad(sad),
    .busy(busy), .done(done), .best_sad(best_sad), .best_mv(best_mv),
    .cand_count(cand_count), .early_exit(early_exit)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] sad_of(input logic [511:0] a, input logic [511:0] b);
    int acc = 0;
    for (int i = 0; i < 64; i++) begin
      int x = int'(a[8*i +: 8]);
      int y = int'(b[8*i +: 8]);
      acc += (x > y) ? x - y : y - x;
    end
    return acc[13:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] make_blk(input int s);
    logic [511:0] r = '0;
    int rem = s;
    for (int i = 0; i < 64; i++) begin
      int v = (rem > 255) ? 255 : rem;
      r[8*i +: 8] = v[7:0];
      rem -= v;
    end
    return r;
  endfunction

  // SAD engine: samples xpixels/ypixels, result valid LAT edges later.
  always @(posedge clk) begin
    eng[0] <= sad_of(xpixels, ypixels);
    for (int i = 1; i < LAT; i++) eng[i] <= eng[i-1];
  end
  assign sad = eng[LAT-1];

  // mode 0: valid always, 1: vpat then always, 2: random with noise in DRAIN.
  task automatic run_search(input int n, input logic [511:0] cur, input bit ten,
                            input logic [13:0] th, input int mode, input bit noise);
    mst_e st;
    int   cyc, idx, vi;
    bit   v, acc, alast, hit, fin;
    sb_t  e;
    start = 1'b1; cur_block = cur; thresh_en = ten; thresh = th;
    cand_valid = 1'b0; cand_last = 1'b0;
    @(posedge clk);
    m_best = 14'h3FFF; m_mv = '0; m_cnt = 0; m_ee = 1'b0; sb.delete();
    st = M_RUN; cyc = 0; idx = 0; vi = 0; fin = 1'b0; last_acc = -1; done_at = -1;
    @(negedge clk);
    start = 1'b0; cur_block = rand512(); thresh_en = ~ten; thresh = ~th;
    while (!fin) begin
      checks++;
      if (cand_ready !== (st == M_RUN)) begin
        errors++; $display("FAIL cand_ready cyc=%0d got=%b exp=%b", cyc, cand_ready, st == M_RUN);
      end
      checks++;
      if (done !== (st == M_DONE)) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, st == M_DONE);
      end
      checks++;
      if (busy !== (st != M_DONE)) begin
        errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, st != M_DONE);
      end
      if (st == M_DONE) begin
        done_at = cyc;
        fin = 1'b1;
        checks++;
        if (best_sad !== m_best) begin
          errors++; $display("FAIL best_sad got=%0d exp=%0d", best_sad, m_best);
        end
        checks++;
        if (best_mv !== m_mv) begin
          errors++; $display("FAIL best_mv got=%0d exp=%0d", best_mv, m_mv);
        end
        checks++;
        if (cand_count !== 16'(m_cnt)) begin
          errors++; $display("FAIL cand_count got=%0d exp=%0d", cand_count, m_cnt);
        end
        checks++;
        if (early_exit !== m_ee) begin
          errors++; $display("FAIL early_exit got=%b exp=%b", early_exit, m_ee);
        end
      end
      if (st == M_RUN && idx < n) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (vi < vpat.size()) ? vpat[vi] : 1'b1;
          default: v = ($urandom_range(3) != 0);
        endcase
        vi++;
      end else begin
        v = (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
      end
      cand_valid = v;
      if (idx < n) begin
        cand_pixels = c_pix[idx]; cand_mv = c_mv[idx]; cand_last = (idx == n - 1);
      end else begin
        cand_pixels = rand512(); cand_mv = MVW'($urandom); cand_last = 1'($urandom_range(1));
      end
      start = noise ? ($urandom_range(3) == 0) : 1'b0;
      acc   = v && (st == M_RUN) && (idx < n);
      alast = acc && (idx == n - 1);
      if (acc) begin
        e.s = sad_of(c_pix[idx], cur); e.mv = c_mv[idx]; e.rc = cyc + LAT + 1;
        sb.push_back(e);
        last_acc = cyc;
        idx++;
      end
      @(posedge clk);
      hit = 1'b0;
      if (sb.size() > 0 && sb[0].rc == cyc) begin
        e = sb.pop_front();
        if (m_cnt < 65535) m_cnt++;
        if (e.s < m_best) begin m_best = e.s; m_mv = e.mv; end
        if (ten && e.s <= th) begin m_ee = 1'b1; hit = 1'b1; end
      end
      case (st)
        M_RUN:   if (hit || alast) st = M_DRAIN;
        M_DRAIN: if (sb.size() == 0) st = M_DONE;
        default: ;
      endcase
      cyc++;
      @(negedge clk);
      if (!fin && cyc > 3000) begin
        checks++; errors++;
        $display("FAIL search_timeout got=%0d cycles exp=<=3000", cyc);
        fin = 1'b1;
      end
    end
    start = 1'b0; cand_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({cand_ready, busy, done, early_exit} !== 4'b0000) begin
      errors++; $display("FAIL %s_ctl got=%b exp=0000", tag, {cand_ready, busy, done, early_exit});
    end
    checks++;
    if (best_sad !== 14'h3FFF || best_mv !== '0 || cand_count !== 16'd0) begin
      errors++; $display("FAIL %s_results got=%h/%h/%h exp=3fff/000/0000", tag, best_sad, best_mv, cand_count);
    end
    checks++;
    if (xpixels !== '0 || ypixels !== '0) begin
      errors++; $display("FAIL %s_pixels got=%0d/%0d exp=0/0", tag, xpixels != '0, ypixels != '0);
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1; start = 1'b0; cur_block = '0; thresh_en = 1'b0; thresh = '0;
    cand_valid = 1'b0; cand_pixels = '0; cand_mv = '0; cand_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    aclr = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] b [4] = '{8'd1, 8'd3, 8'd2, 8'd5};
    for (int i = 0; i < 4; i++) begin
      c_pix[i] = {64{b[i]}}; c_mv[i] = MVW'(i + 1);
    end
    run_search(4, '0, 1'b0, '0, 0, 1'b0);
    checks++;
    if (best_sad !== 14'd64 || best_mv !== MVW'(1) || cand_count !== 16'd4) begin
      errors++; $display("FAIL basic_const got=%0d/%0d/%0d exp=64/1/4", best_sad, best_mv, cand_count);
    end
    checks++;
    if (done_at - last_acc !== LAT + 2) begin
      errors++; $display("FAIL done_latency got=%0d exp=%0d", done_at - last_acc, LAT + 2);
    end
  endtask

  task automatic test_tie();
    c_pix[0] = {64{8'd2}}; c_mv[0] = MVW'(7);
    c_pix[1] = {64{8'd2}}; c_mv[1] = MVW'(8);
    c_pix[2] = make_blk(200); c_mv[2] = MVW'(9);
    run_search(3, '0, 1'b0, '0, 0, 1'b0);
    checks++;
    if (best_sad !== 14'd128 || best_mv !== MVW'(7)) begin
      errors++; $display("FAIL tie got=%0d/%0d exp=128/7", best_sad, best_mv);
    end
  endtask

  task automatic test_early_exit();
    int s [10] = '{500, 90, 400, 350, 250, 700, 120, 800, 50, 30};
    for (int i = 0; i < 10; i++) begin
      c_pix[i] = make_blk(s[i]); c_mv[i] = MVW'(i + 100);
    end
    run_search(10, '0, 1'b1, 14'd100, 0, 1'b0);
    checks++;
    if (best_sad !== 14'd90 || best_mv !== MVW'(101) || early_exit !== 1'b1) begin
      errors++; $display("FAIL early_exit_const got=%0d/%0d/%b exp=90/101/1", best_sad, best_mv, early_exit);
    end
  endtask

  task automatic test_bubbles();
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    c_pix[0] = {64{8'd9}}; c_mv[0] = MVW'(20);
    c_pix[1] = {64{8'd4}}; c_mv[1] = MVW'(21);
    c_pix[2] = {64{8'd6}}; c_mv[2] = MVW'(22);
    run_search(3, '0, 1'b0, '0, 1, 1'b0);
    vpat.delete();
    checks++;
    if (cand_count !== 16'd3 || best_sad !== 14'd256 || best_mv !== MVW'(21)) begin
      errors++; $display("FAIL bubbles got=%0d/%0d/%0d exp=3/256/21", cand_count, best_sad, best_mv);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; cur_block = '0; thresh_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cand_valid = 1'b1; cand_pixels = {64{8'd2}}; cand_mv = MVW'(5); cand_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cand_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aclr = 1'b0;
    check_reset_values("reset_mid");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cand_count !== 16'd0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_mid_quiet cyc=%0d got=%b/%0d/%b exp=0/0/0", i, done, cand_count, busy);
      end
    end
    for (int i = 0; i < 5; i++) begin
      c_pix[i] = make_blk(300 - 40 * i + ((i == 2) ? 200 : 0)); c_mv[i] = MVW'(i + 40);
    end
    run_search(5, '0, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [511:0] cur = rand512();
    for (int i = 0; i < 6; i++) begin c_pix[i] = rand512(); c_mv[i] = MVW'($urandom); end
    run_search(6, cur, 1'b0, '0, 0, 1'b0);
    checks++;
    if (done !== 1'b0 || best_sad !== m_best || cand_count !== 16'd6) begin
      errors++; $display("FAIL hold_after_done got=%b/%0d/%0d exp=0/%0d/6", done, best_sad, cand_count, m_best);
    end
    cur = rand512();
    for (int i = 0; i < 3; i++) begin c_pix[i] = rand512(); c_mv[i] = MVW'($urandom); end
    run_search(3, cur, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 1000 && errors < 50; k++) begin
      int n = $urandom_range(40, 1);
      for (int i = 0; i < n; i++) begin c_pix[i] = rand512(); c_mv[i] = MVW'($urandom); end
      run_search(n, rand512(), 1'($urandom_range(1)), 14'($urandom_range(5200, 4000)), 2, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_early_exit();
    test_bubbles();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
